ifid_skid_reg: RTL and testbench

- Parametrised IF→ID pipeline boundary register with a ready/valid handshake.
- Has a 2-entry skid buffer, so downstream backpressure (`out_ready`) never has a combinational path to upstream acceptance (`in_ready`).
- `flush` drops wrong-path instructions when a branch or jump resolves taken.
- Sits between the fetch stage and the decode stage; replaces the fixed-width stall/flush register used on that boundary.

---
 rtl/ifid_skid_reg_if.sv | 26 ++
 rtl/ifid_skid_reg.sv | 143 ++++++++++++++
 tb/tb_ifid_skid_reg.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifid_skid_reg_if.sv
`timescale 1ns/1ps
// ifid_skid_reg_if: valid/ready bundle carrying one {pc, inst} entry.
// master drives valid/pc/inst, slave drives ready.
interface ifid_skid_reg_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;

    modport master (
        output valid,
        output pc,
        output inst,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc,
        input  inst,
        output ready
    );
endinterface

// File: rtl/ifid_skid_reg.sv
`timescale 1ns/1ps
// ifid_skid_reg: IF->ID boundary register with a 2-entry skid buffer.
// Macro IFID_BUBBLE_NOP_EN: flush leaves an explicit NOP bubble at the head.
module ifid_skid_reg #(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013)
) (
    input  logic                    clk,
    input  logic                    rst,
    ifid_skid_reg_if.slave          in_if,
    ifid_skid_reg_if.master         out_if,
    input  logic                    flush,
    output logic [1:0]              level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic              ready_q;
    logic [PC_W-1:0]   head_pc;
    logic [INST_W-1:0] head_inst;
    logic [PC_W-1:0]   skid_pc;
    logic [INST_W-1:0] skid_inst;

    logic in_ready;
    logic out_valid;
    logic push;
    logic pop;
    logic ld_head_in;
    logic ld_head_skid;
    logic ld_head_nop;
    logic ld_skid;

    // ready_q keeps in_ready low until the first edge after reset release
    assign in_ready  = ready_q & (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_if.valid & in_ready;
    assign pop       = out_valid & out_if.ready;

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.pc    = head_pc;
    assign out_if.inst  = head_inst;
    assign level        = state_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Upstream-ready enable, registered so in_ready never sees rst directly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Next state and datapath load selects; flush outranks push/pop
    always_comb begin
        state_d      = state_q;
        ld_head_in   = 1'b0;
        ld_head_skid = 1'b0;
        ld_head_nop  = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
`ifdef IFID_BUBBLE_NOP_EN
            state_d     = ONE;
            ld_head_nop = 1'b1;
`else
            state_d     = EMPTY;
`endif
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d    = ONE;
                        ld_head_in = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        ld_head_in = 1'b1;
                    end else if (push) begin
                        state_d = FULL;
                        ld_skid = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d      = ONE;
                        ld_head_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Head entry: fresh fetch, promoted skid, or flush bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_pc   <= '0;
            head_inst <= '0;
        end else if (ld_head_nop) begin
            head_pc   <= in_if.pc;
            head_inst <= NOP_INST;
        end else if (ld_head_in) begin
            head_pc   <= in_if.pc;
            head_inst <= in_if.inst;
        end else if (ld_head_skid) begin
            head_pc   <= skid_pc;
            head_inst <= skid_inst;
        end
    end

    // Skid entry catches the push that arrives while the head is stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_pc   <= '0;
            skid_inst <= '0;
        end else if (ld_skid) begin
            skid_pc   <= in_if.pc;
            skid_inst <= in_if.inst;
        end
    end

endmodule

// File: tb/tb_ifid_skid_reg.sv
`timescale 1ns/1ps
// tb_ifid_skid_reg: table vectors, directed corner cases and a
// queue-model random run for ifid_skid_reg (32-bit and 64/16 builds).
module tb_ifid_skid_reg;

`ifdef IFID_BUBBLE_NOP_EN
    localparam bit BUB = 1'b1;
`else
    localparam bit BUB = 1'b0;
`endif
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [15:0] NOP16 = 16'h0001;
    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifid_skid_reg_if #(.PC_W(32), .INST_W(32)) a_in ();
    ifid_skid_reg_if #(.PC_W(32), .INST_W(32)) a_out ();
    ifid_skid_reg_if #(.PC_W(64), .INST_W(16)) b_in ();
    ifid_skid_reg_if #(.PC_W(64), .INST_W(16)) b_out ();

    logic       a_fl;
    logic       b_fl;
    logic [1:0] a_lv;
    logic [1:0] b_lv;

    ifid_skid_reg u_a (
        .clk    (clk),
        .rst    (rst),
        .in_if  (a_in),
        .out_if (a_out),
        .flush  (a_fl),
        .level  (a_lv)
    );

    ifid_skid_reg #(
        .PC_W     (64),
        .INST_W   (16),
        .NOP_INST (16'h0001)
    ) u_b (
        .clk    (clk),
        .rst    (rst),
        .in_if  (b_in),
        .out_if (b_out),
        .flush  (b_fl),
        .level  (b_lv)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return {pc[15:0] ^ 16'hC0DE, pc[15:0]};
    endfunction

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        fl;
        logic        ordy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic [1:0]  elv;
        logic        eir;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    function automatic vec_t row(input logic v, input logic [31:0] pc,
                                 input logic fl, input logic ordy,
                                 input logic ev, input logic [31:0] epc,
                                 input logic [31:0] einst,
                                 input logic [1:0] elv, input logic eir);
        vec_t r;
        r.v = v; r.pc = pc; r.fl = fl; r.ordy = ordy;
        r.ev = ev; r.epc = epc; r.einst = einst;
        r.elv = elv; r.eir = eir;
        return r;
    endfunction

    vec_t tbl[19];
    ent_t mq[$];

    task automatic chk_a(input string nm, input logic ev,
                         input logic [31:0] epc, input logic [31:0] ei,
                         input logic [1:0] elv, input logic eir);
        chk({nm, " valid"}, 64'(a_out.valid), 64'(ev));
        chk({nm, " pc"}, 64'(a_out.pc), 64'(epc));
        chk({nm, " inst"}, 64'(a_out.inst), 64'(ei));
        chk({nm, " level"}, 64'(a_lv), 64'(elv));
        chk({nm, " in_ready"}, 64'(a_in.ready), 64'(eir));
    endtask

    initial begin
        logic [31:0] fpc;
        logic [31:0] fin;
        logic [1:0]  flv;
        fpc = BUB ? 32'h80 : 32'h20;
        fin = BUB ? NOP : mk(32'h20);
        flv = BUB ? 2'd1 : 2'd0;
        tbl[0]  = row(T, 32'h00, F, T, T, 32'h00, mk(32'h00), 2'd1, T);
        tbl[1]  = row(T, 32'h04, F, T, T, 32'h04, mk(32'h04), 2'd1, T);
        tbl[2]  = row(T, 32'h08, F, T, T, 32'h08, mk(32'h08), 2'd1, T);
        tbl[3]  = row(T, 32'h10, F, T, T, 32'h10, mk(32'h10), 2'd1, T);
        tbl[4]  = row(T, 32'h14, F, F, T, 32'h10, mk(32'h10), 2'd2, F);
        tbl[5]  = row(T, 32'h18, F, F, T, 32'h10, mk(32'h10), 2'd2, F);
        tbl[6]  = row(T, 32'h18, F, T, T, 32'h14, mk(32'h14), 2'd1, T);
        tbl[7]  = row(T, 32'h18, F, T, T, 32'h18, mk(32'h18), 2'd1, T);
        tbl[8]  = row(F, 32'h00, F, T, F, 32'h18, mk(32'h18), 2'd0, T);
        tbl[9]  = row(T, 32'h20, F, F, T, 32'h20, mk(32'h20), 2'd1, T);
        tbl[10] = row(T, 32'h24, F, F, T, 32'h20, mk(32'h20), 2'd2, F);
        tbl[11] = row(T, 32'h80, T, F, BUB, fpc, fin, flv, T);
        tbl[12] = row(F, 32'h00, F, T, F, fpc, fin, 2'd0, T);
        tbl[13] = row(T, 32'h30, F, F, T, 32'h30, mk(32'h30), 2'd1, T);
        tbl[14] = row(T, 32'h34, F, T, T, 32'h34, mk(32'h34), 2'd1, T);
        tbl[15] = row(F, 32'h00, F, T, F, 32'h34, mk(32'h34), 2'd0, T);
        tbl[16] = row(T, 32'h40, F, F, T, 32'h40, mk(32'h40), 2'd1, T);
        fpc = BUB ? 32'h44 : 32'h40;
        fin = BUB ? NOP : mk(32'h40);
        tbl[17] = row(F, 32'h44, T, T, BUB, fpc, fin, flv, T);
        tbl[18] = row(F, 32'h00, F, T, F, fpc, fin, 2'd0, T);

        a_in.valid = 1'b0; a_in.pc = '0; a_in.inst = '0;
        a_out.ready = 1'b0; a_fl = 1'b0;
        b_in.valid = 1'b0; b_in.pc = '0; b_in.inst = '0;
        b_out.ready = 1'b0; b_fl = 1'b0;

        // reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            chk_a("reset", F, 32'h0, 32'h0, 2'd0, F);
            chk("reset b in_ready", 64'(b_in.ready), 64'(0));
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset a in_ready", 64'(a_in.ready), 64'(1));
        chk("post-reset b in_ready", 64'(b_in.ready), 64'(1));

        // wide build: fill, then flush while FULL
        @(negedge clk);
        b_in.valid = 1'b1;
        b_in.pc = 64'hFEDC_BA98_7654_3210;
        b_in.inst = 16'hBEEF;
        @(posedge clk); #1;
        chk("wide push pc", b_out.pc, 64'hFEDC_BA98_7654_3210);
        chk("wide push inst", 64'(b_out.inst), 64'(16'hBEEF));
        chk("wide push level", 64'(b_lv), 64'(1));
        @(negedge clk);
        b_in.pc = 64'h8765_4321_0FED_CBA8;
        b_in.inst = 16'h1234;
        @(posedge clk); #1;
        chk("wide full level", 64'(b_lv), 64'(2));
        chk("wide full in_ready", 64'(b_in.ready), 64'(0));
        chk("wide full head", b_out.pc, 64'hFEDC_BA98_7654_3210);
        @(negedge clk);
        b_fl = 1'b1;
        b_in.pc = 64'h8000_0000_0000_0080;
        b_in.inst = 16'h5555;
        @(posedge clk); #1;
        chk("wide flush valid", 64'(b_out.valid), 64'(BUB));
        chk("wide flush level", 64'(b_lv), BUB ? 64'd1 : 64'd0);
        chk("wide flush pc", b_out.pc,
            BUB ? 64'h8000_0000_0000_0080 : 64'hFEDC_BA98_7654_3210);
        chk("wide flush inst", 64'(b_out.inst),
            BUB ? 64'(NOP16) : 64'(16'hBEEF));
        @(negedge clk);
        b_fl = 1'b0; b_in.valid = 1'b0; b_out.ready = 1'b1;
        @(posedge clk); #1;
        chk("wide drain valid", 64'(b_out.valid), 64'(0));
        chk("wide drain level", 64'(b_lv), 64'(0));
        @(negedge clk);
        b_out.ready = 1'b0;

        // table-driven vectors on the 32-bit build
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            a_in.valid = tbl[i].v;
            a_in.pc = tbl[i].pc;
            a_in.inst = mk(tbl[i].pc);
            a_fl = tbl[i].fl;
            a_out.ready = tbl[i].ordy;
            @(posedge clk); #1;
            chk_a($sformatf("row%0d", i), tbl[i].ev, tbl[i].epc,
                  tbl[i].einst, tbl[i].elv, tbl[i].eir);
        end

        // random traffic against a FIFO-of-two model
        mq.delete();
        for (int c = 0; c < 500; c++) begin
            logic v, o, fl, push, pop;
            logic [31:0] pc, inst;
            ent_t e;
            @(negedge clk);
            v = ($urandom % 4) != 0;
            o = ($urandom % 3) != 0;
            fl = ($urandom % 16) == 0;
            pc = $urandom & 32'hFFFF_FFFC;
            inst = $urandom;
            a_in.valid = v; a_in.pc = pc; a_in.inst = inst;
            a_fl = fl; a_out.ready = o;
            chk("rnd pre in_ready", 64'(a_in.ready),
                64'(mq.size() < 2));
            push = v && (mq.size() < 2);
            pop = o && (mq.size() > 0);
            if (fl) begin
                mq.delete();
                if (BUB) begin
                    e.pc = pc; e.inst = NOP;
                    mq.push_back(e);
                end
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    e.pc = pc; e.inst = inst;
                    mq.push_back(e);
                end
            end
            @(posedge clk); #1;
            chk("rnd level", 64'(a_lv), 64'(mq.size()));
            chk("rnd valid", 64'(a_out.valid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("rnd pc", 64'(a_out.pc), 64'(mq[0].pc));
                chk("rnd inst", 64'(a_out.inst), 64'(mq[0].inst));
            end
        end

        // drain, fill to FULL, then asynchronous reset between edges
        @(negedge clk);
        a_fl = 1'b0; a_in.valid = 1'b0; a_out.ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a_in.valid = 1'b1; a_in.pc = 32'h50;
        a_in.inst = mk(32'h50); a_out.ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_in.pc = 32'h54; a_in.inst = mk(32'h54);
        @(posedge clk); #1;
        chk_a("prefill", T, 32'h50, mk(32'h50), 2'd2, F);
        #2;
        rst = 1'b0;
        #1;
        chk_a("async reset", F, 32'h0, 32'h0, 2'd0, F);
        @(negedge clk);
        a_in.valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_a("after reset", F, 32'h0, 32'h0, 2'd0, T);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
